// File: rtl/bitstream_unpacker.sv
// Re-forms LSB-first 8/20-bit tokens from the compressed byte BRAM and streams them out over valid/ready.
// Define UNPACK_SYNC_RD_EN when the BRAM read port is registered (rd_data one cycle after rd_addr).
module bitstream_unpacker #(
    parameter int TOKEN_W = 20,
    parameter int SMALL_W = 8,
    parameter int MEMSIZE = 2048,
    parameter int ADDR_W  = $clog2(MEMSIZE)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  byte_count,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [7:0]         rd_data,
    output logic               tok_valid,
    input  logic               tok_ready,
    output logic [TOKEN_W-1:0] tok_data,
    output logic               tok_large,
    output logic               busy,
    output logic               done,
    output logic               trunc
);
    localparam int BUF_W = 40;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [BUF_W-1:0] bit_buf;
    logic [5:0]       bit_cnt;
    logic [ADDR_W:0]  fetched;
    logic [ADDR_W:0]  limit;
    logic             pending;

    logic             is_large;
    logic             decodable;
    logic             load_tok;
    logic             issue;
    logic             land;
    logic [5:0]       consume_w;
    logic [5:0]       cnt_after;
    logic [BUF_W-1:0] buf_shift;
    logic [BUF_W-1:0] land_word;

    always_comb begin
        is_large  = bit_buf[0];
        decodable = is_large ? (bit_cnt >= 6'(TOKEN_W)) : (bit_cnt >= 6'(SMALL_W));
        load_tok  = (state == RUN) && decodable && (!tok_valid || tok_ready);
        consume_w = load_tok ? (is_large ? 6'(TOKEN_W) : 6'(SMALL_W)) : 6'd0;
        // Consume first, then the landing byte goes in at the reduced count.
        cnt_after = bit_cnt - consume_w;
        buf_shift = bit_buf >> consume_w;
        land_word = BUF_W'(rd_data) << cnt_after;
        issue     = (state == RUN) && (fetched < limit) &&
                    ((bit_cnt + (pending ? 6'd8 : 6'd0)) <= 6'd32);
    end

`ifdef UNPACK_SYNC_RD_EN
    // One read in flight: its byte lands the cycle after its address was issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= 1'b0;
        else          pending <= issue;
    end
    assign land = pending;
`else
    assign pending = 1'b0;
    assign land    = issue;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if ((fetched == limit) && !pending && !decodable && !tok_valid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_buf   <= '0;
            bit_cnt   <= '0;
            fetched   <= '0;
            limit     <= '0;
            rd_addr   <= '0;
            trunc     <= 1'b0;
            tok_valid <= 1'b0;
            tok_data  <= '0;
            tok_large <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                limit   <= {1'b0, byte_count};
                bit_buf <= '0;
                bit_cnt <= '0;
                fetched <= '0;
                rd_addr <= '0;
                trunc   <= 1'b0;
            end else if (state == RUN) begin
                bit_buf <= land ? (buf_shift | land_word) : buf_shift;
                bit_cnt <= land ? (cnt_after + 6'd8) : cnt_after;
                if (issue) begin
                    fetched <= fetched + 1'b1;
                    rd_addr <= rd_addr + 1'b1;
                end
                if (state_nxt == DONE) trunc <= (bit_cnt != 6'd0);
            end

            if (load_tok) begin
                tok_valid <= 1'b1;
                tok_large <= is_large;
                tok_data  <= is_large ? bit_buf[TOKEN_W-1:0]
                                      : {{(TOKEN_W-SMALL_W){1'b0}}, bit_buf[SMALL_W-1:0]};
            end else if (tok_ready) begin
                tok_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_unpacker.sv
// Self-checking bench for bitstream_unpacker: directed vector table, hand sequences and a
// randomized 2045-byte mixed stream against a bit-level reference model.
module tb_bitstream_unpacker;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] byte_count = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              tok_valid;
    logic              tok_ready = 1'b1;
    logic [19:0]       tok_data;
    logic              tok_large;
    logic              busy;
    logic              done;
    logic              trunc;

    bitstream_unpacker dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_count(byte_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_data(tok_data), .tok_large(tok_large), .busy(busy), .done(done), .trunc(trunc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:2047];
`ifdef UNPACK_SYNC_RD_EN
    always @(posedge clk) rd_data <= mem[rd_addr];
`else
    assign rd_data = mem[rd_addr];
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] got_data[$];
    logic        got_large[$];
    int          got_cyc[$];
    logic [19:0] exp_data[$];
    logic        exp_large[$];
    int          stall_err;
    int          max_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit bit_at(input int p);
        logic [7:0] b;
        b = mem[p >> 3];
        return b[p & 7];
    endfunction

    // Reference: walk the bit stream token by token; leftover bits mean truncation.
    task automatic model(input int n, output bit trunc_exp);
        int          pos;
        int          total;
        int          w;
        logic [19:0] v;
        exp_data.delete();
        exp_large.delete();
        total = n * 8;
        pos = 0;
        while (pos < total) begin
            w = bit_at(pos) ? 20 : 8;
            if (pos + w > total) break;
            v = '0;
            for (int k = 0; k < w; k++) v[k] = bit_at(pos + k);
            exp_data.push_back(v);
            exp_large.push_back(w == 20);
            pos += w;
        end
        trunc_exp = (pos != total);
    endtask

    task automatic gen_stream(input int n);
        bit          bits[$];
        bit          lg;
        logic [31:0] v;
        int          w;
        while (bits.size() < n * 8) begin
            lg = 1'($urandom_range(0, 1));
            w = lg ? 20 : 8;
            v = $urandom;
            v[0] = lg;
            for (int k = 0; k < w; k++) bits.push_back(v[k]);
        end
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++) mem[i][k] = bits[i * 8 + k];
    endtask

    task automatic run_readout(input int n, input bit rnd_ready, input int budget,
                               output bit saw_done, output bit trunc_got);
        bit          stall_prev;
        logic [19:0] prev_data;
        logic        prev_large;
        got_data.delete();
        got_large.delete();
        got_cyc.delete();
        stall_err = 0;
        max_cnt = 0;
        saw_done = 1'b0;
        trunc_got = 1'b0;
        stall_prev = 1'b0;
        prev_data = '0;
        prev_large = 1'b0;
        @(posedge clk); #1;
        byte_count = ADDR_W'(n);
        start = 1'b1;
        tok_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (int'(dut.bit_cnt) > max_cnt) max_cnt = int'(dut.bit_cnt);
            if (stall_prev && (!tok_valid || tok_data !== prev_data || tok_large !== prev_large))
                stall_err++;
            if (tok_valid && tok_ready) begin
                got_data.push_back(tok_data);
                got_large.push_back(tok_large);
                got_cyc.push_back(cyc);
            end
            stall_prev = tok_valid && !tok_ready;
            prev_data = tok_data;
            prev_large = tok_large;
            if (done) begin
                saw_done = 1'b1;
                trunc_got = trunc;
                break;
            end
            @(posedge clk); #1;
            tok_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(posedge clk); #1;
        tok_ready = 1'b1;
    endtask

    task automatic compare_model(input string tag, input bit trunc_exp, input bit saw_done,
                                 input bit trunc_got);
        int m;
        check({tag, "_done"}, 64'(saw_done), 64'd1);
        check({tag, "_trunc"}, 64'(trunc_got), 64'(trunc_exp));
        check({tag, "_tok_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        check({tag, "_stall_stable_errs"}, 64'(stall_err), 64'd0);
        check({tag, "_bit_cnt_over40"}, 64'(max_cnt > 40), 64'd0);
        m = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < m; i++) begin
            int e0;
            e0 = n_err;
            check($sformatf("%s_tok%0d_data", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
            check($sformatf("%s_tok%0d_large", tag, i), 64'(got_large[i]), 64'(exp_large[i]));
            if (n_err != e0) break;
        end
    endtask

    typedef struct {
        int               n;
        logic [0:4][7:0]  b;
        int               ntok;
        logic [0:2][19:0] tok;
        logic [0:2]       lg;
        bit               tr;
    } vec_t;

    vec_t vec[6];

    initial begin
        bit saw_done;
        bit trunc_got;
        bit trunc_exp;

        vec[0] = '{3, {8'h02, 8'h04, 8'h06, 8'h00, 8'h00}, 3, {20'h00002, 20'h00004, 20'h00006}, 3'b000, 1'b0};
        vec[1] = '{5, {8'hD1, 8'hBC, 8'h5A, 8'h34, 8'h12}, 2, {20'hABCD1, 20'h12345, 20'h0}, 3'b110, 1'b0};
        vec[2] = '{2, {8'hD1, 8'hBC, 8'h00, 8'h00, 8'h00}, 0, {20'h0, 20'h0, 20'h0}, 3'b000, 1'b1};
        vec[3] = '{0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, {20'h0, 20'h0, 20'h0}, 3'b000, 1'b0};
        vec[4] = '{3, {8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 1, {20'h00003, 20'h0, 20'h0}, 3'b100, 1'b1};
        vec[5] = '{1, {8'hFE, 8'h00, 8'h00, 8'h00, 8'h00}, 1, {20'h000FE, 20'h0, 20'h0}, 3'b000, 1'b0};

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_tok_valid", 64'(tok_valid), 64'd0);
        check("rst_tok_data", 64'(tok_data), 64'd0);
        check("rst_tok_large", 64'(tok_large), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_trunc", 64'(trunc), 64'd0);
        reset_n = 1'b1;

        // Empty readout: done two cycles after start, address never moves
        @(posedge clk); #1;
        byte_count = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bc0_done_c1", 64'(done), 64'd0);
        check("bc0_busy_c1", 64'(busy), 64'd1);
        check("bc0_rd_addr_c1", 64'(rd_addr), 64'd0);
        @(negedge clk);
        check("bc0_done_c2", 64'(done), 64'd1);
        check("bc0_trunc_c2", 64'(trunc), 64'd0);
        check("bc0_rd_addr_c2", 64'(rd_addr), 64'd0);
        @(negedge clk);
        check("bc0_done_c3", 64'(done), 64'd0);
        check("bc0_busy_c3", 64'(busy), 64'd0);

        // Directed vector table, ready held high
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 5; k++) mem[k] = vec[i].b[k];
            run_readout(vec[i].n, 1'b0, 20 * vec[i].n + 40, saw_done, trunc_got);
            check($sformatf("v%0d_done", i), 64'(saw_done), 64'd1);
            check($sformatf("v%0d_trunc", i), 64'(trunc_got), 64'(vec[i].tr));
            check($sformatf("v%0d_ntok", i), 64'(got_data.size()), 64'(vec[i].ntok));
            check($sformatf("v%0d_rd_addr_end", i), 64'(rd_addr), 64'(vec[i].n));
            for (int t = 0; t < vec[i].ntok && t < got_data.size(); t++) begin
                check($sformatf("v%0d_tok%0d_data", i, t), 64'(got_data[t]), 64'(vec[i].tok[t]));
                check($sformatf("v%0d_tok%0d_large", i, t), 64'(got_large[t]), 64'(vec[i].lg[t]));
            end
            if (i == 0 && got_cyc.size() == 3) begin
                check("v0_back_to_back_1", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
                check("v0_back_to_back_2", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
            end
        end

        // Long mixed stream with random backpressure
        gen_stream(2045);
        model(2045, trunc_exp);
        run_readout(2045, 1'b1, 40000, saw_done, trunc_got);
        compare_model("rand", trunc_exp, saw_done, trunc_got);
        check("rand_rd_addr_end", 64'(rd_addr), 64'd2045);

        // Reset in the middle of a readout, then restart from scratch
        gen_stream(300);
        model(300, trunc_exp);
        run_readout(300, 1'b1, 60, saw_done, trunc_got);
        check("mid_not_done_yet", 64'(saw_done), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rd_addr", 64'(rd_addr), 64'd0);
        check("midrst_tok_valid", 64'(tok_valid), 64'd0);
        check("midrst_tok_data", 64'(tok_data), 64'd0);
        check("midrst_tok_large", 64'(tok_large), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_trunc", 64'(trunc), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_readout(300, 1'b1, 8000, saw_done, trunc_got);
        compare_model("restart", trunc_exp, saw_done, trunc_got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bitstream_unpacker.md
# bitstream_unpacker

Reads the variable-length compressed bitstream back out of the compressed storage BRAM through its byte read port and re-forms the original 8-bit and 20-bit tokens, LSB-first. It is the readout counterpart to the bit packer. It feeds tokens to the decompressor or UART framer over a valid/ready handshake and reports completion and truncation.

## Interface
- `TOKEN_W`, 20: large token width (DATA_WIDTH+4).
- `SMALL_W`, 8: small token width.
- `MEMSIZE`, 2048: compressed BRAM depth in bytes; `ADDR_W = $clog2(MEMSIZE)` = 11.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a readout; ignored unless IDLE.
- `byte_count` in ADDR_W: number of valid bytes in BRAM (compmem_counter); sampled on `start`.
- `rd_addr` out ADDR_W: BRAM byte read address.
- `rd_data` in 8: BRAM read data.
- `tok_valid` out 1: `tok_data` holds a token.
- `tok_ready` in 1: consumer accepts the token.
- `tok_data` out TOKEN_W: token, zero-extended when small.
- `tok_large` out 1: 1 = 20-bit token, 0 = 8-bit token.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of readout.
- `trunc` out 1: sticky flag; leftover bits existed at end; cleared on `start`.

## Operation
- Stream format: LSB-first bit packing. Token type is bit 0 of the token: 0 = 8-bit token, 1 = 20-bit token. The compressor guarantees this.
- State: 40-bit `buf`, 6-bit `bit_cnt` (0..40), `fetched` (ADDR_W+1 bits), `limit`, 1-bit `pending` (always 0 without the macro).
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. Latch `limit`=`byte_count`. Clear `buf`, `bit_cnt`, `fetched`, `rd_addr`, `trunc`.
  - RUN → DONE when `fetched==limit`, `pending==0`, no token is decodable and `tok_valid==0`.
  - DONE → IDLE after one cycle, with `done`=1 in that cycle. `trunc` is set if `bit_cnt!=0` on entry.
- Fetch issue: issue when `fetched<limit` and `bit_cnt + 8*pending <= 32`. An issue increments `rd_addr` and `fetched`. `rd_addr` saturates at `limit` and never wraps.
- Byte land: `buf |= rd_data << bit_cnt'` and `bit_cnt += 8`. `bit_cnt'` is the count after any same-cycle consume.
- Decode: a token is decodable when either condition holds:
  - `buf[0]==0` and `bit_cnt>=8`: small token.
  - `buf[0]==1` and `bit_cnt>=20`: large token.
- Output: when decodable and the output register is empty (or being emptied this cycle), load `tok_data`, `tok_large` and `tok_valid`=1. Shift `buf` right by 8 or 20 and subtract the same amount from `bit_cnt`.
- Same-cycle consume and land: shift first, then OR the landed byte at the reduced count, as the packer does. `bit_cnt` never exceeds 40.
- `byte_count==0`: RUN → DONE immediately, `trunc`=0.
- Backpressure: `tok_data`/`tok_large` are held stable while `tok_valid && !tok_ready`. Fetching continues until the buffer threshold is reached.
- Reset mid-readout: return to IDLE immediately and drop all buffered bits.

## Timing
- Reset values: `rd_addr`=0, `tok_valid`=0, `tok_data`=0, `tok_large`=0, `busy`=0, `done`=0, `trunc`=0.
- `rd_addr` is registered. Default read is combinational: the byte lands in the same cycle its address is presented.
- First token: `tok_valid` rises 2 cycles after `start` for a small first token (combinational read).
- Throughput with `tok_ready` held high:
  - Small tokens: 1 per cycle.
  - Large tokens: 2 per 5 cycles (byte-rate limited).
- `done` asserts 1 cycle after the final token handshake completes when no bits remain.

## Configuration
- `UNPACK_SYNC_RD_EN`:
  - Defined: the BRAM read is registered, so `rd_data` is valid one cycle after `rd_addr`. `pending` tracks one in-flight byte, and at most one read is outstanding. First-token latency grows by 1 cycle and throughput is unchanged.
  - Undefined: combinational read, `pending` is tied to 0, and the read cost is as stated above.

## Test plan
- Bytes 0x02,0x04,0x06 with `byte_count`=3 and ready high → three small tokens 0x02, 0x04, 0x06 on consecutive cycles, then `done` with `trunc`=0.
- Bytes D1,BC,5A,34,12 with `byte_count`=5 → large 0xABCD1 then large 0x12345, then `done`, `trunc`=0.
- Bytes D1,BC with `byte_count`=2 → no token is emitted, `done` pulses, `trunc`=1 (16 bits left over).
- Mixed 8/20 stream of 2045 bytes with `tok_ready` toggled randomly → token sequence matches the reference model, `tok_data` is stable while stalled, and `bit_cnt` is never above 40.
- `byte_count`=0 → `done` pulses 2 cycles after `start`, and no `rd_addr` increment occurs.
- `reset_n` low mid-stream, then `start` again → outputs return to reset values and the readout restarts from address 0 with identical tokens. Run both with and without `UNPACK_SYNC_RD_EN`.
